control_unit: RTL



---
 rtl/cpu_pkg.sv | 74 +++++++
 rtl/control_unit_if.sv | 34 +++
 rtl/opcode_decoder.sv | 37 +++
 rtl/control_unit.sv | 98 +++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared constants and types for the accumulator CPU microsequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int CW   = 25;
  localparam int OPW  = 8;
  localparam int ALUW = 4;

  localparam int CB_PC_INC   = 0;
  localparam int CB_PC_LD    = 1;
  localparam int CB_MAR_PC   = 2;
  localparam int CB_MAR_MBR  = 3;
  localparam int CB_MEM_RD   = 4;
  localparam int CB_MEM_WR   = 5;
  localparam int CB_MBR_ACC  = 6;
  localparam int CB_BR_MBR   = 7;
  localparam int CB_ACC_ALU  = 9;
  localparam int CB_IR_LD    = 11;
  localparam int CB_ALU_LSB  = 12;
  localparam int CB_HALT_IND = 16;

  localparam logic [ALUW-1:0] ALU_NOP   = 4'd0;
  localparam logic [ALUW-1:0] ALU_ADD   = 4'd1;
  localparam logic [ALUW-1:0] ALU_SUB   = 4'd2;
  localparam logic [ALUW-1:0] ALU_AND   = 4'd3;
  localparam logic [ALUW-1:0] ALU_OR    = 4'd4;
  localparam logic [ALUW-1:0] ALU_NOT   = 4'd5;
  localparam logic [ALUW-1:0] ALU_SHR   = 4'd6;
  localparam logic [ALUW-1:0] ALU_SHL   = 4'd7;
  localparam logic [ALUW-1:0] ALU_PASSB = 4'd8;

  localparam logic [OPW-1:0] OP_STORE = 8'h01;
  localparam logic [OPW-1:0] OP_LOAD  = 8'h02;
  localparam logic [OPW-1:0] OP_ADD   = 8'h03;
  localparam logic [OPW-1:0] OP_SUB   = 8'h04;
  localparam logic [OPW-1:0] OP_JGEZ  = 8'h05;
  localparam logic [OPW-1:0] OP_JMP   = 8'h06;
  localparam logic [OPW-1:0] OP_HALT  = 8'h07;
  localparam logic [OPW-1:0] OP_AND   = 8'h09;
  localparam logic [OPW-1:0] OP_OR    = 8'h0A;
  localparam logic [OPW-1:0] OP_NOT   = 8'h0B;
  localparam logic [OPW-1:0] OP_SHR   = 8'h0C;
  localparam logic [OPW-1:0] OP_SHL   = 8'h0D;

  typedef enum logic [3:0] {
    S_F0   = 4'd0,
    S_F1   = 4'd1,
    S_F2   = 4'd2,
    S_D0   = 4'd3,
    S_EM   = 4'd4,
    S_EW   = 4'd5,
    S_EB   = 4'd6,
    S_EA   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  // CLS_MEM covers every instruction that reads an operand and then uses the ALU
  typedef enum logic [2:0] {
    CLS_NOP   = 3'd0,
    CLS_MEM   = 3'd1,
    CLS_STORE = 3'd2,
    CLS_JMP   = 3'd3,
    CLS_JGEZ  = 3'd4,
    CLS_ALU1  = 3'd5,
    CLS_HALT  = 3'd6
  } iclass_t;

endpackage

`default_nettype wire

// File: rtl/control_unit_if.sv
// ============================================================================
// control_unit_if : opcode/status inputs and control word outputs of the sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

interface control_unit_if;
  import cpu_pkg::*;

  logic [OPW-1:0] IRout;
  logic           acc_neg;
  logic           mem_ready;
  logic [CW-1:0]  control;
  logic           halted;

  modport master (
    output IRout,
    output acc_neg,
    output mem_ready,
    input  control,
    input  halted
  );

  modport slave (
    input  IRout,
    input  acc_neg,
    input  mem_ready,
    output control,
    output halted
  );

endinterface

`default_nettype wire

// File: rtl/opcode_decoder.sv
// ============================================================================
// opcode_decoder : maps the IR opcode to an instruction class and ALU operation
// Rev 1.0
// ============================================================================
`default_nettype none

module opcode_decoder
  import cpu_pkg::*;
(
  input  logic [OPW-1:0]  opcode,
  output iclass_t         iclass,
  output logic [ALUW-1:0] alu_op
);

  always_comb begin
    iclass = CLS_NOP;
    alu_op = ALU_NOP;
    case (opcode)
      OP_STORE: iclass = CLS_STORE;
      OP_LOAD:  begin iclass = CLS_MEM;  alu_op = ALU_PASSB; end
      OP_ADD:   begin iclass = CLS_MEM;  alu_op = ALU_ADD;   end
      OP_SUB:   begin iclass = CLS_MEM;  alu_op = ALU_SUB;   end
      OP_AND:   begin iclass = CLS_MEM;  alu_op = ALU_AND;   end
      OP_OR:    begin iclass = CLS_MEM;  alu_op = ALU_OR;    end
      OP_JGEZ:  iclass = CLS_JGEZ;
      OP_JMP:   iclass = CLS_JMP;
      OP_HALT:  iclass = CLS_HALT;
      OP_NOT:   begin iclass = CLS_ALU1; alu_op = ALU_NOT;   end
      OP_SHR:   begin iclass = CLS_ALU1; alu_op = ALU_SHR;   end
      OP_SHL:   begin iclass = CLS_ALU1; alu_op = ALU_SHL;   end
      default:  begin iclass = CLS_NOP;  alu_op = ALU_NOP;   end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
// control_unit : fetch/decode/execute microsequencer producing the CPU control word
// Rev 1.0
// ============================================================================
`default_nettype none

module control_unit
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  control_unit_if.slave bus
);

  state_t          state;
  iclass_t         iclass;
  logic [ALUW-1:0] alu_op;
  logic [CW-1:0]   ctl;

  opcode_decoder u_dec (
    .opcode (bus.IRout),
    .iclass (iclass),
    .alu_op (alu_op)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_F0;
    end else begin
      case (state)
        S_F0: state <= S_F1;
        S_F1: if (bus.mem_ready) state <= S_F2;
        S_F2: state <= S_D0;
        S_D0: begin
          case (iclass)
            CLS_MEM, CLS_STORE: state <= S_EM;
            CLS_HALT:           state <= S_HALT;
            default:            state <= S_F0;
          endcase
        end
        // STORE spends EM moving ACC into MBR, so it never waits here
        S_EM: begin
          if (iclass == CLS_STORE)  state <= S_EW;
          else if (bus.mem_ready)   state <= S_EB;
        end
        S_EW:   if (bus.mem_ready) state <= S_F0;
        S_EB:   state <= S_EA;
        S_EA:   state <= S_F0;
        S_HALT: state <= S_HALT;
        default: state <= S_F0;
      endcase
    end
  end

  always_comb begin
    ctl = '0;
    if (!rst) begin
      case (state)
        S_F0: ctl[CB_MAR_PC] = 1'b1;
        S_F1: begin
          ctl[CB_MEM_RD] = 1'b1;
          ctl[CB_PC_INC] = bus.mem_ready;
        end
        S_F2: ctl[CB_IR_LD] = 1'b1;
        S_D0: begin
          case (iclass)
            CLS_MEM, CLS_STORE: ctl[CB_MAR_MBR] = 1'b1;
            CLS_JMP:            ctl[CB_PC_LD]   = 1'b1;
            CLS_JGEZ:           ctl[CB_PC_LD]   = ~bus.acc_neg;
            CLS_ALU1: begin
              ctl[CB_ALU_LSB +: ALUW] = alu_op;
              ctl[CB_ACC_ALU]         = 1'b1;
            end
            default: ctl = '0;
          endcase
        end
        S_EM: begin
          if (iclass == CLS_STORE) ctl[CB_MBR_ACC] = 1'b1;
          else                     ctl[CB_MEM_RD]  = 1'b1;
        end
        S_EW: ctl[CB_MEM_WR] = 1'b1;
        S_EB: ctl[CB_BR_MBR] = 1'b1;
        S_EA: begin
          ctl[CB_ALU_LSB +: ALUW] = alu_op;
          ctl[CB_ACC_ALU]         = 1'b1;
        end
        S_HALT: ctl[CB_HALT_IND] = 1'b1;
        default: ctl = '0;
      endcase
    end
  end

  assign bus.control = ctl;
  assign bus.halted  = (state == S_HALT) && !rst;

endmodule

`default_nettype wire
